digest_lane_scanner: RTL and testbench

//  Sequential compare stage that consumes the 4:1 digest mux. Captures four 128-bit candidate

---
 rtl/digest_lane_scanner_pkg.sv | 22 ++
 rtl/digest_lane_scanner_mux.sv | 22 ++
 rtl/digest_lane_scanner.sv | 123 ++++++++++++
 tb/tb_digest_lane_scanner.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/digest_lane_scanner_pkg.sv
// rtl/digest_lane_scanner_pkg.sv - shared widths, FSM encoding and lane priority encoder
package digest_lane_scanner_pkg;

  localparam int DIGEST_W  = 128;
  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Lowest set lane wins; an empty mask reports lane 0.
  function automatic logic [SEL_W-1:0] lowest_lane(input logic [NUM_LANES-1:0] mask);
    lowest_lane = '0;
    for (int k = NUM_LANES - 1; k >= 0; k--) begin
      if (mask[k]) lowest_lane = SEL_W'(k);
    end
  endfunction

endpackage

// File: rtl/digest_lane_scanner_mux.sv
// rtl/digest_lane_scanner_mux.sv - 4:1 digest mux feeding the scanner comparator
module digest_lane_scanner_mux #(
  parameter int W = 128
) (
  input  logic [W-1:0] in1,
  input  logic [W-1:0] in2,
  input  logic [W-1:0] in3,
  input  logic [W-1:0] in4,
  input  logic [1:0]   sel,
  output logic [W-1:0] out
);

  always_comb begin
    case (sel)
      2'd0:    out = in1;
      2'd1:    out = in2;
      2'd2:    out = in3;
      default: out = in4;
    endcase
  end

endmodule

// File: rtl/digest_lane_scanner.sv
// rtl/digest_lane_scanner.sv - steps the digest mux over four lanes and reports matches
module digest_lane_scanner
  import digest_lane_scanner_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [DIGEST_W-1:0]  cand0,
  input  logic [DIGEST_W-1:0]  cand1,
  input  logic [DIGEST_W-1:0]  cand2,
  input  logic [DIGEST_W-1:0]  cand3,
  input  logic [DIGEST_W-1:0]  target,
  input  logic                 abort,
  output logic                 busy,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 found,
  output logic [SEL_W-1:0]     match_idx,
  output logic [NUM_LANES-1:0] match_mask
);

  state_e               state_q;
  logic [SEL_W-1:0]     sel_q;
  logic [DIGEST_W-1:0]  cand_q [NUM_LANES];
  logic [DIGEST_W-1:0]  target_q;
  logic [NUM_LANES-1:0] mask_q;
  logic [NUM_LANES-1:0] mask_d;
  logic                 in_ready_q;
  logic                 busy_q;
  logic                 out_valid_q;
  logic                 found_q;
  logic [SEL_W-1:0]     match_idx_q;
  logic [NUM_LANES-1:0] match_mask_q;
  logic [DIGEST_W-1:0]  mux_out;

  digest_lane_scanner_mux #(.W(DIGEST_W)) u_mux (
    .in1 (cand_q[0]),
    .in2 (cand_q[1]),
    .in3 (cand_q[2]),
    .in4 (cand_q[3]),
    .sel (sel_q),
    .out (mux_out)
  );

  // Mask as it will stand after this cycle's lane compare; also feeds the result on the last lane.
  always_comb begin
    mask_d        = mask_q;
    mask_d[sel_q] = (mux_out == target_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      sel_q        <= '0;
      for (int k = 0; k < NUM_LANES; k++) cand_q[k] <= '0;
      target_q     <= '0;
      mask_q       <= '0;
      in_ready_q   <= 1'b0;
      busy_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      found_q      <= 1'b0;
      match_idx_q  <= '0;
      match_mask_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          in_ready_q <= 1'b1;
          if (in_valid && in_ready_q) begin
            cand_q[0]  <= cand0;
            cand_q[1]  <= cand1;
            cand_q[2]  <= cand2;
            cand_q[3]  <= cand3;
            target_q   <= target;
            mask_q     <= '0;
            sel_q      <= '0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (abort) begin
            state_q    <= S_IDLE;
            busy_q     <= 1'b0;
            in_ready_q <= 1'b1;
            mask_q     <= '0;
            sel_q      <= '0;
          end else begin
            mask_q <= mask_d;
            sel_q  <= sel_q + SEL_W'(1);
            if (sel_q == SEL_W'(NUM_LANES - 1)) begin
              state_q      <= S_DONE;
              busy_q       <= 1'b0;
              out_valid_q  <= 1'b1;
              found_q      <= |mask_d;
              match_idx_q  <= lowest_lane(mask_d);
              match_mask_q <= mask_d;
            end
          end
        end
        S_DONE: begin
          // Result fields are left untouched so the reporter still sees the last result.
          if (abort || out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            if (abort) mask_q <= '0;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign busy       = busy_q;
  assign out_valid  = out_valid_q;
  assign found      = found_q;
  assign match_idx  = match_idx_q;
  assign match_mask = match_mask_q;

endmodule

// File: tb/tb_digest_lane_scanner.sv
// tb/tb_digest_lane_scanner.sv - scoreboard bench for the digest lane scanner
module tb_digest_lane_scanner;
  import digest_lane_scanner_pkg::*;

  localparam logic [127:0] T0 = 128'h0cc175b9_c0f1b6a8_31c399e2_69772661;
  localparam logic [127:0] L0 = 128'hd3fa8b21_5c0e77d9_a41f3c60_9e2b106e;
  localparam logic [127:0] L1 = 128'hcd3510aa_7f42e9b3_06d85c1e_b3917a48;
  localparam logic [127:0] L2 = 128'hb4972e6d_81c0f5a3_3b9e4d27_c605780d;
  localparam logic [127:0] P  = 128'h5eb63bbb_e01eeed0_93cb22bb_8f5acdc3;
  localparam logic [127:0] Q  = 128'h90015098_3cd24fb0_d6963f7d_28e17f72;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         abort = 1'b0;
  logic         out_ready = 1'b1;
  logic [127:0] cand0 = '0, cand1 = '0, cand2 = '0, cand3 = '0, target = '0;
  logic         in_ready, busy, out_valid, found;
  logic [1:0]   match_idx;
  logic [3:0]   match_mask;

  digest_lane_scanner dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cand0(cand0), .cand1(cand1), .cand2(cand2), .cand3(cand3), .target(target),
    .abort(abort), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .found(found), .match_idx(match_idx), .match_mask(match_mask)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct {
    logic       f;
    logic [1:0] idx;
    logic [3:0] mask;
    int         acc;
  } exp_t;

  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: latency on the rising edge of out_valid, fields on each handshake.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (out_valid && !prev) begin
        if (exp_q.size() == 0) check("unexpected_result", 1, 0);
        else check("latency", cyc - exp_q[0].acc, 4);
      end
      if (out_valid && out_ready && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("found", found, e.f);
        check("match_idx", match_idx, e.idx);
        check("match_mask", match_mask, e.mask);
        check("in_ready_low_in_done", in_ready, 0);
      end
      prev = out_valid;
    end
  end

  // Called at posedge+1; returns at accept edge +1 with in_valid dropped.
  task automatic issue(input logic [127:0] c0, input logic [127:0] c1, input logic [127:0] c2,
                       input logic [127:0] c3, input logic [127:0] t, input logic f,
                       input logic [1:0] i, input logic [3:0] m, input bit push);
    int n;
    n = 0;
    cand0 = c0; cand1 = c1; cand2 = c2; cand3 = c3; target = t;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      check("accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) exp_q.push_back('{f, i, m, cyc});
    cand0 = {4{$urandom()}}; cand1 = {4{$urandom()}};
    cand2 = {4{$urandom()}}; cand3 = {4{$urandom()}}; target = {4{$urandom()}};
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int n;
    #12;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_found", found, 0);
    check("rst_match_idx", match_idx, 0);
    check("rst_match_mask", match_mask, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("in_ready_after_reset", in_ready, 1);

    issue(L0, L1, L2, T0, T0, 1'b1, 2'd3, 4'b1000, 1);
    issue(L0, T0, L2, T0, T0, 1'b1, 2'd1, 4'b1010, 1);
    issue(L0, L1, L2, T0, 128'h0, 1'b0, 2'd0, 4'b0000, 1);
    issue(T0 ^ 128'h1, T0 ^ (128'h1 << 127), T0, T0 ^ (128'h1 << 64), T0, 1'b1, 2'd2, 4'b0100, 1);
    issue(T0, T0, T0, T0, T0, 1'b1, 2'd0, 4'b1111, 1);
    wait_idle();

    // Back-pressure: result held, new offer ignored until a cycle after the handshake.
    out_ready = 1'b0;
    issue(P, Q, L0, L1, Q, 1'b1, 2'd1, 4'b0010, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("stall_out_valid_seen", out_valid, 1);
    cand0 = T0; cand1 = L2; cand2 = T0; cand3 = L1; target = T0;
    in_valid = 1'b1;
    for (int s = 0; s < 3; s++) begin
      check("stall_out_valid", out_valid, 1);
      check("stall_in_ready", in_ready, 0);
      check("stall_found", found, 1);
      check("stall_match_idx", match_idx, 1);
      check("stall_match_mask", match_mask, 4'b0010);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("post_hs_out_valid", out_valid, 0);
    check("post_hs_busy", busy, 0);
    check("post_hs_in_ready", in_ready, 1);
    @(posedge clk); #1;
    check("late_accept_busy", busy, 1);
    check("late_accept_in_ready", in_ready, 0);
    in_valid = 1'b0;
    exp_q.push_back('{1'b1, 2'd0, 4'b0101, cyc});
    wait_idle();

    // Abort on the second scan cycle.
    issue(L0, L1, T0, L2, T0, 1'b1, 2'd2, 4'b0100, 0);
    @(posedge clk); #1;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_busy", busy, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_out_valid", out_valid, 0);
    repeat (6) @(posedge clk);
    #1;
    check("abort_no_result", out_valid, 0);

    // Abort in IDLE does not block acceptance.
    abort = 1'b1;
    issue(L2, P, L0, Q, L0, 1'b1, 2'd2, 4'b0100, 1);
    abort = 1'b0;
    wait_idle();

    // Asynchronous reset between edges during SCAN.
    issue(P, P, P, P, Q, 1'b0, 2'd0, 4'b0000, 0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 0);
    check("arst_out_valid", out_valid, 0);
    check("arst_found", found, 0);
    check("arst_match_idx", match_idx, 0);
    check("arst_match_mask", match_mask, 0);
    check("arst_in_ready", in_ready, 0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("arst_release_in_ready", in_ready, 1);
    issue(Q, L1, L2, T0, Q, 1'b1, 2'd0, 4'b0001, 1);
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
